// File: rtl/picoblaze_port_bridge.sv
// -----------------------------------------------------------------------------
// picoblaze_port_bridge
//
// I/O port bridge between a KCPSM6 core and its peripheral controllers.
// Decodes port_id into N_OUT write registers and N_IN read ports, each with a
// one-cycle access pulse, and adds an event/interrupt unit: sticky rising-edge
// flags, an interrupt mask and a request FSM driving interrupt/interrupt_ack.
//
// Optional feature macro: PB_EVT_SYNC_EN
//   defined   : two-flop synchroniser on every in_event line before edge
//               detection (flag latency 3 cycles, asynchronous sources allowed)
//   undefined : in_event must be clk-synchronous, flag latency 1 cycle
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous reset, active low
//   port_id        in   KCPSM6 port address
//   out_port       in   KCPSM6 write data
//   write_strobe   in   OUTPUT strobe (full port_id decode)
//   k_write_strobe in   OUTPUTK strobe (port_id[3:0] decode only)
//   read_strobe    in   INPUT strobe
//   in_port        out  registered read data to KCPSM6
//   interrupt      out  interrupt request to KCPSM6
//   interrupt_ack  in   KCPSM6 acknowledge
//   out_bus        out  output registers, reg i = [i*DATA_W +: DATA_W]
//   out_wr_pulse   out  one-cycle pulse, coincident with the new out_bus value
//   in_bus         in   input port data, same packing as out_bus
//   in_rd_pulse    out  one-cycle pulse the cycle after the read_strobe cycle
//   in_event       in   event lines (level)
// -----------------------------------------------------------------------------
module picoblaze_port_bridge #(
  parameter int unsigned         DATA_W    = 8,
  parameter int unsigned         ADDR_W    = 8,
  parameter int unsigned         N_OUT     = 4,
  parameter int unsigned         N_IN      = 4,
  parameter logic [ADDR_W-1:0]   OUT_BASE  = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0]   IN_BASE   = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0]   EVT_PORT  = ADDR_W'(8'hF0),
  parameter logic [ADDR_W-1:0]   MASK_PORT = ADDR_W'(8'hF1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       port_id,
  input  logic [DATA_W-1:0]       out_port,
  input  logic                    write_strobe,
  input  logic                    k_write_strobe,
  input  logic                    read_strobe,
  output logic [DATA_W-1:0]       in_port,
  output logic                    interrupt,
  input  logic                    interrupt_ack,
  output logic [N_OUT*DATA_W-1:0] out_bus,
  output logic [N_OUT-1:0]        out_wr_pulse,
  input  logic [N_IN*DATA_W-1:0]  in_bus,
  output logic [N_IN-1:0]         in_rd_pulse,
  input  logic [N_IN-1:0]         in_event
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  irq_state_t          state, state_nxt;

  logic [N_OUT-1:0]    wr_hit_p0;
  logic [N_IN-1:0]     rd_hit_p0;
  logic [DATA_W-1:0]   rd_data_p0;
  logic                evt_sel_p0;
  logic                mask_sel_p0;
  logic                mask_wr_p0;
  logic                evt_clr_p0;

  logic [N_IN-1:0]     mask;
  logic [N_IN-1:0]     flags;
  logic [N_IN-1:0]     evt_line;
  logic [N_IN-1:0]     evt_hist;
  logic [N_IN-1:0]     evt_rise;

  // ---- stage p0: address decode and read mux (combinational) ----
  assign evt_sel_p0  = (port_id == EVT_PORT);
  assign mask_sel_p0 = (port_id == MASK_PORT);
  assign mask_wr_p0  = write_strobe && mask_sel_p0;
  assign evt_clr_p0  = read_strobe && evt_sel_p0;

  always_comb begin
    wr_hit_p0 = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      // OUTPUTK only carries a 4-bit port address, so its decode wraps mod 16.
      wr_hit_p0[i] = (write_strobe   && (port_id == OUT_BASE + ADDR_W'(i))) ||
                     (k_write_strobe && (port_id[3:0] == OUT_BASE[3:0] + 4'(i)));
    end
  end

  always_comb begin
    rd_hit_p0  = '0;
    rd_data_p0 = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (port_id == IN_BASE + ADDR_W'(i)) begin
        rd_data_p0   = in_bus[i*DATA_W +: DATA_W];
        rd_hit_p0[i] = read_strobe && !evt_sel_p0 && !mask_sel_p0;
      end
    end
    // Event and mask ports shadow any overlapping input port.
    if (evt_sel_p0) begin
      rd_data_p0 = DATA_W'(flags);
    end else if (mask_sel_p0) begin
      rd_data_p0 = DATA_W'(mask);
    end
  end

  // ---- stage p1: registered port outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_bus      <= '0;
      out_wr_pulse <= '0;
      in_rd_pulse  <= '0;
      in_port      <= '0;
      mask         <= '0;
    end else begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (wr_hit_p0[i]) out_bus[i*DATA_W +: DATA_W] <= out_port;
      end
      out_wr_pulse <= wr_hit_p0;
      in_rd_pulse  <= rd_hit_p0;
      in_port      <= rd_data_p0;
      if (mask_wr_p0) mask <= out_port[N_IN-1:0];
    end
  end

  // ---- event path: optional synchroniser, edge detect, sticky flags ----
`ifdef PB_EVT_SYNC_EN
  logic [N_IN-1:0] evt_sync_p0, evt_sync_p1;

  // Reset to 1s so a line already high at reset release is not an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_sync_p0 <= '1;
      evt_sync_p1 <= '1;
    end else begin
      evt_sync_p0 <= in_event;
      evt_sync_p1 <= evt_sync_p0;
    end
  end

  assign evt_line = evt_sync_p1;
`else
  assign evt_line = in_event;
`endif

  assign evt_rise = evt_line & ~evt_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_hist <= '1;
      flags    <= '0;
    end else begin
      evt_hist <= evt_line;
      // The clear removes exactly what this read returns; a new edge wins.
      flags    <= (evt_clr_p0 ? '0 : flags) | evt_rise;
    end
  end

  // ---- interrupt request FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|(flags & mask)) state_nxt = REQ;
      REQ:     if (interrupt_ack)   state_nxt = SVC;
      SVC:     if (evt_clr_p0)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign interrupt = (state == REQ);

endmodule

// File: tb/tb_picoblaze_port_bridge.sv
module tb_picoblaze_port_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        write_strobe, k_write_strobe, read_strobe, interrupt_ack;
  logic [7:0]  in_port;
  logic        interrupt;
  logic [31:0] out_bus;
  logic [3:0]  out_wr_pulse;
  logic [31:0] in_bus;
  logic [3:0]  in_rd_pulse;
  logic [3:0]  in_event;

  picoblaze_port_bridge dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
    .read_strobe(read_strobe), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .out_bus(out_bus), .out_wr_pulse(out_wr_pulse),
    .in_bus(in_bus), .in_rd_pulse(in_rd_pulse), .in_event(in_event)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: register file, mask, flags, last event levels, and
  // whether a request is pending or being serviced.
  logic [7:0] m_reg [4];
  logic [3:0] m_mask, m_flags, m_prev, m_wrp, m_rdp;
  logic [7:0] m_inport;
  bit         m_req, m_svc;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_mask = 0; m_flags = 0; m_prev = 4'hF; m_wrp = 0; m_rdp = 0;
    m_inport = 0; m_req = 0; m_svc = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] of, om, rise;
    bit ev_rd;
    of = m_flags; om = m_mask;
    ev_rd = read_strobe && (port_id == 8'hF0);
    if (port_id == 8'hF0)      m_inport = {4'h0, of};
    else if (port_id == 8'hF1) m_inport = {4'h0, om};
    else if (port_id < 8'd4)   m_inport = in_bus[int'(port_id)*8 +: 8];
    else                       m_inport = 8'h00;
    m_wrp = 0;
    for (int i = 0; i < 4; i++) begin
      if ((write_strobe && port_id == 8'(i)) || (k_write_strobe && port_id[3:0] == 4'(i))) begin
        m_reg[i] = out_port;
        m_wrp[i] = 1'b1;
      end
    end
    if (write_strobe && port_id == 8'hF1) m_mask = out_port[3:0];
    m_rdp = 0;
    if (read_strobe && port_id < 8'd4) m_rdp[port_id[1:0]] = 1'b1;
    rise = in_event & ~m_prev;
    m_prev = in_event;
    m_flags = (ev_rd ? 4'h0 : of) | rise;
    if (m_req) begin
      if (interrupt_ack) begin m_req = 0; m_svc = 1; end
    end else if (m_svc) begin
      if (ev_rd) m_svc = 0;
    end else if ((of & om) != 0) begin
      m_req = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_bus"}, out_bus, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    check({tag, ".wr_pulse"}, out_wr_pulse, m_wrp);
    check({tag, ".rd_pulse"}, in_rd_pulse, m_rdp);
    check({tag, ".in_port"}, in_port, m_inport);
    check({tag, ".interrupt"}, interrupt, m_req);
  endtask

  task automatic idle_inputs();
    write_strobe = 0; k_write_strobe = 0; read_strobe = 0; interrupt_ack = 0;
    port_id = 8'h77; out_port = 8'h00;
  endtask

  typedef struct {
    logic        ws, kws, rs;
    logic [7:0]  pid, data;
    logic [31:0] e_bus;
    logic [3:0]  e_wrp, e_rdp;
    logic [7:0]  e_inp;
  } vec_t;

  vec_t tbl [15];

  initial begin
    //            ws kws rs  pid    data   out_bus        wrp      rdp      in_port
    tbl[0]  = '{0, 0, 0, 8'h77, 8'h00, 32'h00000000, 4'b0000, 4'b0000, 8'h00};
    tbl[1]  = '{1, 0, 0, 8'h02, 8'hA5, 32'h00A50000, 4'b0100, 4'b0000, 8'h33};
    tbl[2]  = '{0, 0, 0, 8'h77, 8'h00, 32'h00A50000, 4'b0000, 4'b0000, 8'h00};
    tbl[3]  = '{0, 1, 0, 8'h31, 8'h3C, 32'h00A53C00, 4'b0010, 4'b0000, 8'h00};
    tbl[4]  = '{1, 0, 0, 8'h50, 8'hEE, 32'h00A53C00, 4'b0000, 4'b0000, 8'h00};
    tbl[5]  = '{0, 0, 0, 8'h03, 8'h00, 32'h00A53C00, 4'b0000, 4'b0000, 8'h5A};
    tbl[6]  = '{0, 0, 1, 8'h03, 8'h00, 32'h00A53C00, 4'b0000, 4'b1000, 8'h5A};
    tbl[7]  = '{0, 0, 0, 8'h77, 8'h00, 32'h00A53C00, 4'b0000, 4'b0000, 8'h00};
    tbl[8]  = '{1, 0, 0, 8'hF1, 8'hFF, 32'h00A53C00, 4'b0000, 4'b0000, 8'h00};
    tbl[9]  = '{0, 0, 0, 8'hF1, 8'h00, 32'h00A53C00, 4'b0000, 4'b0000, 8'h0F};
    tbl[10] = '{1, 0, 0, 8'hF1, 8'h00, 32'h00A53C00, 4'b0000, 4'b0000, 8'h0F};
    tbl[11] = '{0, 0, 0, 8'hF1, 8'h00, 32'h00A53C00, 4'b0000, 4'b0000, 8'h00};
    tbl[12] = '{0, 0, 1, 8'h00, 8'h00, 32'h00A53C00, 4'b0000, 4'b0001, 8'h11};
    tbl[13] = '{0, 1, 0, 8'hF3, 8'h77, 32'h77A53C00, 4'b1000, 4'b0000, 8'h00};
    tbl[14] = '{0, 0, 0, 8'h77, 8'h00, 32'h77A53C00, 4'b0000, 4'b0000, 8'h00};

    reset = 0;
    idle_inputs();
    in_bus = 32'h5A332211;
    in_event = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_bus", out_bus, 32'h0);
    check("rst.in_port", in_port, 8'h0);
    check("rst.interrupt", interrupt, 1'b0);
    check("rst.pulses", {out_wr_pulse, in_rd_pulse}, 8'h0);
    #2 reset = 1;

    // Table-driven port access vectors.
    for (int v = 0; v < 15; v++) begin
      write_strobe = tbl[v].ws; k_write_strobe = tbl[v].kws; read_strobe = tbl[v].rs;
      port_id = tbl[v].pid; out_port = tbl[v].data;
      step();
      check($sformatf("vec%0d.out_bus", v), out_bus, tbl[v].e_bus);
      check($sformatf("vec%0d.wr_pulse", v), out_wr_pulse, tbl[v].e_wrp);
      check($sformatf("vec%0d.rd_pulse", v), in_rd_pulse, tbl[v].e_rdp);
      check($sformatf("vec%0d.in_port", v), in_port, tbl[v].e_inp);
      check($sformatf("vec%0d.interrupt", v), interrupt, 1'b0);
    end

    // Interrupt handshake with mask 0010.
    idle_inputs();
    write_strobe = 1; port_id = 8'hF1; out_port = 8'h02; step();
    idle_inputs();
    in_event = 4'b0010; step();
    check("irq.before", interrupt, 1'b0);
    in_event = 4'b0000; step();
    check("irq.raised", interrupt, 1'b1);
    step();
    check("irq.held", interrupt, 1'b1);
    port_id = 8'hF0; step();
    check("irq.flags_peek", in_port, 8'h02);
    check("irq.held2", interrupt, 1'b1);
    interrupt_ack = 1; step();
    check("irq.acked", interrupt, 1'b0);
    interrupt_ack = 0; step();
    check("irq.svc", interrupt, 1'b0);
    read_strobe = 1; step();
    check("irq.evt_read", in_port, 8'h02);
    read_strobe = 0; step();
    check("irq.flags_cleared", in_port, 8'h00);
    check("irq.idle", interrupt, 1'b0);

    // Edge coinciding with the clear, and a masked-off event.
    idle_inputs();
    write_strobe = 1; port_id = 8'hF1; out_port = 8'h00; step();
    idle_inputs();
    in_event = 4'b0100; step();
    in_event = 4'b0000; step();
    port_id = 8'hF0; step();
    check("mask0.flag2", in_port, 8'h04);
    check("mask0.no_irq", interrupt, 1'b0);
    read_strobe = 1; in_event = 4'b0001; step();
    check("clr.returned", in_port, 8'h04);
    read_strobe = 0; in_event = 4'b0000; step();
    check("clr.edge_wins", in_port, 8'h01);
    check("clr.no_irq", interrupt, 1'b0);
    read_strobe = 1; step();
    read_strobe = 0; step();
    check("clr.final", in_port, 8'h00);

    // Asynchronous reset while a request is pending.
    idle_inputs();
    write_strobe = 1; port_id = 8'hF1; out_port = 8'h01; step();
    idle_inputs();
    in_event = 4'b0001; step();
    in_event = 4'b0000; step();
    check("arst.req", interrupt, 1'b1);
    #2 reset = 0; in_event = 4'hF;
    #1;
    check("arst.interrupt", interrupt, 1'b0);
    check("arst.out_bus", out_bus, 32'h0);
    check("arst.in_port", in_port, 8'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1;
    port_id = 8'hF0; step();
    check("arst.flags", in_port, 8'h00);
    port_id = 8'hF1; step();
    check("arst.mask", in_port, 8'h00);
    step();
    check("arst.no_irq", interrupt, 1'b0);
    in_event = 4'h0; idle_inputs(); step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      int unsigned r;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2, 3: port_id = 8'(r);
        4:          port_id = 8'hF0;
        5:          port_id = 8'hF1;
        6:          port_id = 8'($urandom);
        default:    port_id = {4'($urandom), 4'($urandom_range(0, 3))};
      endcase
      out_port       = 8'($urandom);
      write_strobe   = ($urandom_range(0, 3) == 0);
      k_write_strobe = ($urandom_range(0, 5) == 0);
      read_strobe    = ($urandom_range(0, 2) == 0);
      interrupt_ack  = ($urandom_range(0, 3) == 0);
      in_bus         = $urandom;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) in_event[b] = ~in_event[b];
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
